// File: rtl/mdio_pkg.sv
// mdio_pkg: MDIO frame constants and peripheral state encoding shared by the peripheral and its bench
package mdio_pkg;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] ST_PAT = 2'b01;
    localparam logic [1:0] TA_PAT = 2'b10;
    localparam int W_ST    = 2;
    localparam int W_OP    = 2;
    localparam int W_PHY   = 5;
    localparam int W_REG   = 5;
    localparam int W_TA    = 2;
    localparam int W_DATA  = 16;
    localparam int W_HDR   = W_OP + W_PHY + W_REG;
    localparam int W_FRAME = W_ST + W_HDR + W_TA + W_DATA;
    typedef enum logic [2:0] {IDLE, START, HDR, TA_W, WDATA, TA_R, RDATA, SKIP} mdio_state_t;
endpackage

// File: rtl/mdio_regfile.sv
// mdio_regfile: 32x16 register file, synchronous write on wr_stb, one-clk registered read on rd_stb
module mdio_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_stb,
    input  logic        rd_stb,
    input  logic [4:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data
);
    logic [15:0] mem [32];

    always_ff @(posedge clk)
        if (wr_stb) mem[addr] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) rd_data <= '0;
        else if (rd_stb) rd_data <= mem[addr];
endmodule

// File: rtl/mdio_peripheral.sv
// mdio_peripheral: MDIO management slave decoding clause-22 frames into register-file strobes and serving reads
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        PHY_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] REG_RD_DATA,
    output logic        FRAME_ERR
);
    mdio_state_t state, state_d;
    logic        mdc_q, rise, fall, cap_q;
    logic [4:0]  cnt, cnt_d, addr_d;
    logic [15:0] sh, sh_d, sh_in, tx, tx_d, wr_data_d;
    logic [1:0]  op;
    logic        mdio_in_d, phy_oe_d, wr_stb_d, rd_stb_d, err_d;

    assign rise  = MDC & ~mdc_q;
    assign fall  = ~MDC & mdc_q;
    assign sh_in = {sh[14:0], MDIO_OUT};
    assign op    = sh_in[W_PHY+W_REG+1 -: 2];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sh_d      = sh;
        tx_d      = tx;
        mdio_in_d = MDIO_IN;
        phy_oe_d  = PHY_OE;
        addr_d    = ADDR;
        wr_data_d = WR_DATA;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE:  if (rise && MDIO_OE && MDIO_OUT == ST_PAT[1]) state_d = START;
            START: if (rise && MDIO_OUT == ST_PAT[0]) begin
                state_d = HDR;
                cnt_d   = '0;
            end
            HDR: if (rise) begin
                sh_d  = sh_in;
                cnt_d = cnt + 5'd1;
                if (cnt == 5'(W_HDR - 1)) begin
                    cnt_d = '0;
                    if (op != OP_WR && op != OP_RD) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end else if (sh_in[W_REG +: W_PHY] != PHY_ADDR) begin
                        state_d = SKIP;
                    end else begin
                        addr_d   = sh_in[W_REG-1:0];
                        rd_stb_d = op == OP_RD;
                        state_d  = op == OP_RD ? TA_R : TA_W;
                    end
                end
            end
            TA_W: if (rise) begin
                sh_d  = sh_in;
                cnt_d = cnt + 5'd1;
                if (cnt == 5'(W_TA - 1)) begin
                    cnt_d   = '0;
                    err_d   = sh_in[1:0] != TA_PAT;
                    state_d = sh_in[1:0] == TA_PAT ? WDATA : IDLE;
                end
            end
            WDATA: if (rise) begin
                sh_d  = sh_in;
                cnt_d = cnt + 5'd1;
                if (!MDIO_OE) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == 5'(W_DATA - 1)) begin
                    wr_data_d = sh_in;
                    wr_stb_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            TA_R: begin
                // cap_q marks the clk where the register file output is valid
                if (cap_q) tx_d = REG_RD_DATA;
                if (fall && cnt == '0) begin
                    phy_oe_d  = 1'b1;
                    mdio_in_d = 1'b0;
                    cnt_d     = 5'd1;
                end else if (fall) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: if (fall && cnt != 5'(W_DATA)) begin
                mdio_in_d = tx[15];
                tx_d      = {tx[14:0], 1'b0};
                cnt_d     = cnt + 5'd1;
            end else if (rise && cnt == 5'(W_DATA)) begin
                phy_oe_d  = 1'b0;
                mdio_in_d = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            SKIP: if (rise) begin
                cnt_d = cnt + 5'd1;
                if (cnt == 5'(W_TA + W_DATA - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mdc_q     <= 1'b0;
            cap_q     <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            tx        <= '0;
            MDIO_IN   <= 1'b1;
            PHY_OE    <= 1'b0;
            ADDR      <= '0;
            WR_DATA   <= '0;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_d;
            mdc_q     <= MDC;
            cap_q     <= RD_STB;
            cnt       <= cnt_d;
            sh        <= sh_d;
            tx        <= tx_d;
            MDIO_IN   <= mdio_in_d;
            PHY_OE    <= phy_oe_d;
            ADDR      <= addr_d;
            WR_DATA   <= wr_data_d;
            WR_STB    <= wr_stb_d;
            RD_STB    <= rd_stb_d;
            FRAME_ERR <= err_d;
        end
    end
endmodule
